// File: rtl/fir_pkg.sv
// Shared widths, coefficient storage type and constants for the 8-tap FIR filter.
// Coefficients are Q1.7, so the reset set {127,0,...} passes samples almost unchanged.
package fir_pkg;

  localparam int NTAPS  = 8;
  localparam int SHIFT  = 7;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 19;

  typedef logic signed [DATA_W-1:0] coef_array_t [NTAPS];

  localparam coef_array_t COEF_RESET = '{8'sd127, 8'sd0, 8'sd0, 8'sd0,
                                         8'sd0,   8'sd0, 8'sd0, 8'sd0};

  localparam logic signed [DATA_W-1:0] SAT_MAX = 8'sd127;
  localparam logic signed [DATA_W-1:0] SAT_MIN = -8'sd128;

endpackage

// File: rtl/fir_mac.sv
// Combinational multiply-accumulate for one output: the new sample against h[0],
// the delay line against h[1..7], then a Q1.7 rescale and clip to 8 bits.
module fir_mac
  import fir_pkg::*;
(
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] taps  [NTAPS],
  input  logic signed [DATA_W-1:0] coefs [NTAPS],
  output logic signed [DATA_W-1:0] result,
  output logic                     sat
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] scaled;

  // Each 8x8 product fits in 16 bits; eight of them fit in 19 bits without overflow.
  always_comb begin
    acc = ACC_W'(sample) * ACC_W'(coefs[0]);
    for (int i = 1; i < NTAPS; i++) begin
      acc = acc + ACC_W'(taps[i-1]) * ACC_W'(coefs[i]);
    end
    scaled = acc >>> SHIFT;
  end

  always_comb begin
    result = scaled[DATA_W-1:0];
    sat    = 1'b0;
    if (scaled > ACC_W'(SAT_MAX)) begin
      result = SAT_MAX;
      sat    = 1'b1;
    end else if (scaled < ACC_W'(SAT_MIN)) begin
      result = SAT_MIN;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/fir_filter_top.sv
// TinyTapeout wrapper around the FIR: decodes the control strobes on uio_in,
// holds the delay line, coefficient bank and registered output.
module fir_filter_top
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic                     in_valid;
  logic                     coef_we;
  logic [2:0]               coef_addr;
  logic                     unused_uio;
  logic signed [DATA_W-1:0] sample;

  logic signed [DATA_W-1:0] taps  [NTAPS];
  logic signed [DATA_W-1:0] coefs [NTAPS];

  logic signed [DATA_W-1:0] mac_result;
  logic                     mac_sat;

  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic              out_valid;

  logic do_write;
  logic do_accept;

  assign in_valid   = uio_in[0];
  assign coef_we    = uio_in[1];
  assign coef_addr  = uio_in[4:2];
  assign unused_uio = ^uio_in[7:5];
  assign sample     = ui_in;

  // A coefficient write wins over a sample in the same cycle.
  assign do_write  = ena & coef_we;
  assign do_accept = ena & in_valid & ~coef_we;

  fir_mac u_mac (
    .sample (sample),
    .taps   (taps),
    .coefs  (coefs),
    .result (mac_result),
    .sat    (mac_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps  <= '{default: '0};
      coefs <= COEF_RESET;
    end else begin
      if (do_write) begin
        coefs[coef_addr] <= sample;
      end
      if (do_accept) begin
        taps[0] <= sample;
        for (int i = 1; i < NTAPS; i++) begin
          taps[i] <= taps[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= do_accept;
      if (do_accept) begin
        out_data <= mac_result;
        out_sat  <= mac_sat;
      end
    end
  end

  assign uo_out  = out_data;
  assign uio_out = {out_sat, out_valid, 6'b000000};
  assign uio_oe  = 8'hC0;

endmodule

// File: tb/tb_fir_filter_top.sv
// Scoreboard bench for fir_filter_top: a behavioural FIR model pushes expected
// outputs when samples are driven; a negedge monitor pops them on each out_valid.
module tb_fir_filter_top;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;

  logic signed [7:0] model_h [8];
  logic signed [7:0] model_x [8];
  logic [8:0]        exp_q [$];

  fir_filter_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 8; i++) begin
      model_h[i] = 8'sd0;
      model_x[i] = 8'sd0;
    end
    model_h[0] = 8'sd127;
    exp_q.delete();
  endfunction

  // Integer reference: full-precision sum, floor-divide by 128, then clip.
  function automatic void modelAccept(input logic signed [7:0] s);
    int acc;
    int r;
    logic [8:0] e;
    acc = int'(s) * int'(model_h[0]);
    for (int i = 1; i < 8; i++) acc += int'(model_x[i-1]) * int'(model_h[i]);
    r = acc >>> 7;
    if (r > 127)       e = {1'b1, 8'h7F};
    else if (r < -128) e = {1'b1, 8'h80};
    else               e = {1'b0, r[7:0]};
    exp_q.push_back(e);
    for (int i = 7; i > 0; i--) model_x[i] = model_x[i-1];
    model_x[0] = s;
  endfunction

  // One cycle of stimulus, driven at the falling edge.
  task automatic applyStimulus(input logic [7:0] data, input logic iv, input logic we,
                               input logic [2:0] addr, input logic en);
    @(negedge clk);
    ena    = en;
    ui_in  = data;
    uio_in = {3'b101, addr, we, iv};
    if (en && we)      model_h[addr] = data;
    else if (en && iv) modelAccept(data);
  endtask

  task automatic sendSample(input logic [7:0] data);
    applyStimulus(data, 1'b1, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && uio_out[6] === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'(uo_out), 32'hFFFF_FFFF);
      end else begin
        checkOutput("out", 32'({uio_out[7], uo_out}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] held;
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    checkOutput("rst_uo_out", 32'(uo_out), 32'h00);
    checkOutput("rst_uio_out", 32'(uio_out), 32'h00);
    checkOutput("uio_oe", 32'(uio_oe), 32'hC0);

    // ena low must block both accept and pulse
    held = uo_out;
    applyStimulus(8'h37, 1'b1, 1'b0, 3'd0, 1'b0);
    idle(1);
    checkOutput("ena0_valid", 32'(uio_out[6]), 32'h0);
    checkOutput("ena0_hold", 32'(uo_out), 32'(held));

    // Default coefficients
    sendSample(8'd100);
    sendSample(8'd0);
    sendSample(8'h80);
    idle(2);
    checkOutput("neg_hold", 32'(uo_out), 32'h81);
    checkOutput("idle_valid_low", 32'(uio_out), 32'h00);

    // Mid-stream async reset with a fresh output on the pins
    sendSample(8'd5);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_uo_out", 32'(uo_out), 32'h04);
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_uo_out", 32'(uo_out), 32'h00);
    checkOutput("async_rst_uio_out", 32'(uio_out), 32'h00);
    @(negedge clk);
    ena = 1'b1;
    uio_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    sendSample(8'd10);
    idle(2);
    checkOutput("post_rst_sample", 32'(uo_out), 32'd9);

    // coef_we beats in_valid: h[0]=0, no shift, no pulse
    applyStimulus(8'd0, 1'b1, 1'b1, 3'd0, 1'b1);
    idle(1);
    checkOutput("we_priority_valid", 32'(uio_out[6]), 32'h0);
    sendSample(8'd50);
    idle(2);
    checkOutput("we_priority_out", 32'(uo_out), 32'h00);

    // Flush history, then program all taps to 0.5
    for (int i = 0; i < 8; i++) sendSample(8'd0);
    for (int a = 0; a < 8; a++) applyStimulus(8'd64, 1'b0, 1'b1, 3'(a), 1'b1);
    for (int i = 0; i < 8; i++) sendSample(8'd64);
    idle(1);
    checkOutput("sat_flag", 32'(uio_out[7]), 32'h1);
    for (int i = 0; i < 8; i++) sendSample(8'd0);
    idle(1);
    checkOutput("sat_clear", 32'(uio_out[7]), 32'h0);

    // Impulse response: eight outputs of 32
    sendSample(8'd64);
    for (int i = 0; i < 7; i++) sendSample(8'd0);
    idle(3);
    checkOutput("impulse_tail", 32'(uo_out), 32'd32);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
